gate_truth_checker: RTL and testbench

- Self-contained sequencer/checker for 2-input logic gates; the consuming end of the gate stimulus pattern.
- Drives the four input vectors (00, 01, 10, 11) onto a DUT gate and samples the DUT output for each vector.
- Compares each sample against a parameterised expected truth table and reports pass/fail plus a per-vector mismatch map.
- Sits beside any 2-input gate module (OR, AND, XOR, ...) in synthesizable self-test wrappers and benches.

---
 rtl/gate_truth_checker.sv | 108 ++++++++++
 tb/tb_gate_truth_checker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// Sequencer/checker for a 2-input gate: steps {A,B} through 00..11, samples C and compares with TRUTH.
// Optional GATE_CHECK_STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module gate_truth_checker #(
  parameter logic [3:0]  TRUTH       = 4'b1110,
  parameter int unsigned HOLD_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_map,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 2);

  state_t     state_reg;
  logic [1:0] index_reg;
  logic [7:0] hold_reg;
  logic       mismatch;
  logic       last_vector;
  logic [2:0] err_count_next;
  logic [1:0] index_next;

  // Case-inequality so an X/Z on C counts as a mismatch; synthesis sees a plain compare.
  assign mismatch       = (C !== TRUTH[index_reg]);
  assign err_count_next = err_count + {2'b00, mismatch};
  assign index_next     = index_reg + 2'd1;

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
  assign last_vector = (index_reg == 2'd3) || mismatch;
`else
  assign last_vector = (index_reg == 2'd3);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      index_reg <= 2'd0;
      hold_reg  <= 8'd0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_map   <= 4'd0;
      err_count <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          A    <= 1'b0;
          B    <= 1'b0;
          if (start) begin
            err_map   <= 4'd0;
            err_count <= 3'd0;
            pass      <= 1'b0;
            index_reg <= 2'd0;
            hold_reg  <= 8'd0;
            busy      <= 1'b1;
            state_reg <= DRIVE;
          end
        end
        DRIVE: begin
          if (hold_reg == HOLD_LAST) begin
            state_reg <= SAMPLE;
          end else begin
            hold_reg <= hold_reg + 8'd1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_map[index_reg] <= 1'b1;
            err_count          <= err_count_next;
          end
          if (last_vector) begin
            state_reg <= FINISH;
            done      <= 1'b1;
            busy      <= 1'b0;
            A         <= 1'b0;
            B         <= 1'b0;
            pass      <= (err_count_next == 3'd0);
          end else begin
            // New vector is presented on the cycle after the sample.
            index_reg <= index_next;
            hold_reg  <= 8'd0;
            A         <= index_next[1];
            B         <= index_next[0];
            state_reg <= DRIVE;
          end
        end
        FINISH: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: OR/AND/const/delayed DUT models, reset abort and ignored starts.
module tb_gate_truth_checker;

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  localparam int H1 = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start1, start2;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic       a2, b2, c2, busy2, done2, pass2;
  logic [3:0] map1, map2;
  logic [2:0] cnt1, cnt2;
  int         cmode;
  int         n_checks = 0;
  int         n_fail = 0;
  bit  [17:0] dl1 = '0;
  bit  [17:0] dl2 = '0;

  // 18-cycle delayed OR models for the settling tests.
  always @(posedge clk) begin
    dl1 <= {dl1[16:0], a1 | b1};
    dl2 <= {dl2[16:0], a2 | b2};
  end

  always_comb begin
    c1 = a1 | b1;
    case (cmode)
      1:       c1 = a1 & b1;
      2:       c1 = 1'b1;
      3:       c1 = dl1[17];
      default: c1 = a1 | b1;
    endcase
  end
  assign c2 = dl2[17];

  gate_truth_checker #(.TRUTH(4'b1110), .HOLD_CYCLES(H1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .C(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_map(map1), .err_count(cnt1)
  );

  gate_truth_checker #(.TRUTH(4'b1110), .HOLD_CYCLES(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .C(c2),
    .busy(busy2), .done(done2), .pass(pass2), .err_map(map2), .err_count(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (edge 0).
  task automatic run1(input string tag, input int s1, input int s2, input bit fin_start,
                      input int exp_lat);
    int cnt, ab_bad, busy_bad, idx, lat;
    bit clr_ok;
    ab_bad = 0; busy_bad = 0; lat = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cnt = 1;
    clr_ok = (pass1 === 1'b0) && (map1 === 4'd0) && (cnt1 === 3'd0);
    while (cnt <= 4 * H1 + 10) begin
      if (done1 === 1'b1) begin
        lat = cnt;
        break;
      end
      if (busy1 !== 1'b1) busy_bad++;
      idx = (cnt - 1) / H1;
      if ({a1, b1} !== idx[1:0]) ab_bad++;
      start1 = (cnt == s1) || (cnt == s2);
      @(negedge clk);
      cnt++;
    end
    start1 = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_ab_seq_errors"}, ab_bad, 0);
    check({tag, "_busy_gaps"}, busy_bad, 0);
    check({tag, "_cleared_at_start"}, {31'd0, clr_ok}, 1);
    check({tag, "_busy_at_done"}, {31'd0, busy1}, 0);
    check({tag, "_ab_at_done"}, {30'd0, a1, b1}, 0);
    if (fin_start) start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check({tag, "_done_one_cycle"}, {31'd0, done1}, 0);
    repeat (3) @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, busy1, done1}, 0);
    $display("run %s lat=%0d pass=%0b err_map=%b err_count=%0d", tag, lat, pass1, map1, cnt1);
  endtask

  task automatic expect1(input string tag, input bit p, input int m, input int c);
    check({tag, "_pass"}, {31'd0, pass1}, {31'd0, p});
    check({tag, "_err_map"}, {28'd0, map1}, m);
    check({tag, "_err_count"}, {29'd0, cnt1}, c);
  endtask

  initial begin
    int lat2, cnt, dones;
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; cmode = 0;
    repeat (3) @(negedge clk);
    check("reset_ab", {30'd0, a1, b1}, 0);
    check("reset_busy_done", {30'd0, busy1, done1}, 0);
    check("reset_results", {24'd0, pass1, map1, cnt1}, 0);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);

    cmode = 0;
    run1("or", 0, 0, 1'b0, 81);
    expect1("or", 1'b1, 0, 0);

    cmode = 1;
    run1("and", 0, 0, 1'b0, STOP ? 41 : 81);
    expect1("and", 1'b0, STOP ? 4'b0010 : 4'b0110, STOP ? 1 : 2);

    cmode = 2;
    run1("one", 0, 0, 1'b0, STOP ? 21 : 81);
    expect1("one", 1'b0, 4'b0001, 1);
    run1("one_again", 0, 0, 1'b0, STOP ? 21 : 81);
    expect1("one_again", 1'b0, 4'b0001, 1);

    cmode = 3;
    repeat (20) @(negedge clk);
    run1("delay18_h20", 0, 0, 1'b0, 81);
    expect1("delay18_h20", 1'b1, 0, 0);

    // HOLD_CYCLES=4 instance: delayed output never settles in time.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cnt = 1; lat2 = 0;
    while (cnt < 40) begin
      if (done2 === 1'b1) begin
        lat2 = cnt;
        break;
      end
      @(negedge clk);
      cnt++;
    end
    check("delay18_h4_latency", lat2, STOP ? 9 : 17);
    check("delay18_h4_pass", {31'd0, pass2}, 0);
    check("delay18_h4_err_map", {28'd0, map2}, STOP ? 4'b0010 : 4'b1110);
    check("delay18_h4_err_count", {29'd0, cnt2}, STOP ? 1 : 3);
    $display("run delay18_h4 lat=%0d pass=%0b err_map=%b err_count=%0d", lat2, pass2, map2, cnt2);

    // Reset at cycle 30 of a run aborts it.
    cmode = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_ab", {30'd0, a1, b1}, 0);
    check("midreset_busy_done", {30'd0, busy1, done1}, 0);
    check("midreset_results", {24'd0, pass1, map1, cnt1}, 0);
    dones = 0;
    repeat (100) begin
      @(negedge clk);
      if (done1 === 1'b1 || busy1 === 1'b1) dones++;
    end
    check("midreset_no_done", dones, 0);
    $display("run midreset aborted, activity_after=%0d", dones);
    run1("after_reset", 0, 0, 1'b0, 81);
    expect1("after_reset", 1'b1, 0, 0);

    // Starts at cycles 5 and 80 while busy, and one during FINISH, are all ignored.
    run1("busy_starts", 5, 80, 1'b1, 81);
    expect1("busy_starts", 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
